dff_pipe_en: RTL

// - Parametrised multi-stage enabled register pipeline with per-stage valid tracking,

---
 rtl/dff_pipe_pkg.sv | 16 +
 rtl/dff_en_stage.sv | 37 +++
 rtl/dff_pipe_en.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the enabled register pipeline.
package dff_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 3;
  localparam int unsigned CHG_CNT_W = 16;
  localparam logic [CHG_CNT_W-1:0] CHG_CNT_MAX = 16'hFFFF;

  // Occupancy counter width: enough to hold 0..depth, never narrower than 1 bit.
  function automatic int unsigned occ_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : dff_pipe_pkg

// File: rtl/dff_en_stage.sv
// One pipeline stage: data + valid register with enable, valid clear and sync reset.
module dff_en_stage
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Reset beats clear, clear beats enable; data is untouched by a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data  <= RESET_VAL;
      r_valid <= 1'b0;
    end else if (clr_valid) begin
      r_valid <= 1'b0;
    end else if (enable) begin
      r_data  <= i_d;
      r_valid <= i_valid;
    end
  end

  assign o_q     = r_data;
  assign o_valid = r_valid;

endmodule : dff_en_stage

// File: rtl/dff_pipe_en.sv
// Stallable multi-stage delay line with valid tracking, flush and occupancy.
// Optional q change detection is built only when PIPE_CHANGE_DETECT_EN is defined.
module dff_pipe_en
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [occ_w(DEPTH)-1:0]    occupancy,
  output logic                       q_changed,
  output logic [CHG_CNT_W-1:0]       change_cnt
);

  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic [WIDTH-1:0] w_stage_d [DEPTH];
  logic [DEPTH-1:0] w_stage_v;

  // Stage chain: stage 0 takes the input, each later stage takes its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] w_in_d;
    logic             w_in_v;

    if (gi == 0) begin : g_head
      assign w_in_d = d;
      assign w_in_v = d_valid;
    end else begin : g_body
      assign w_in_d = w_stage_d[gi-1];
      assign w_in_v = w_stage_v[gi-1];
    end

    dff_en_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .clr_valid (flush),
      .i_d       (w_in_d),
      .i_valid   (w_in_v),
      .o_q       (w_stage_d[gi]),
      .o_valid   (w_stage_v[gi])
    );
  end

  assign q       = w_stage_d[DEPTH-1];
  assign q_valid = w_stage_v[DEPTH-1];

  logic [OCC_W-1:0] r_occ;

  // Running count of valid stages: one in from d_valid, one out from the last stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (enable) begin
      r_occ <= r_occ + OCC_W'(d_valid) - OCC_W'(w_stage_v[DEPTH-1]);
    end
  end

  assign occupancy = r_occ;

`ifdef PIPE_CHANGE_DETECT_EN
  logic [WIDTH-1:0]     w_next_q;
  logic                 w_next_v;
  logic                 w_diff;
  logic [WIDTH-1:0]     r_ref;
  logic                 r_ref_v;
  logic                 r_chg;
  logic [CHG_CNT_W-1:0] r_cnt;

  // Value that the last stage will load on the next enabled edge.
  if (DEPTH == 1) begin : g_next_in
    assign w_next_q = d;
    assign w_next_v = d_valid;
  end else begin : g_next_stage
    assign w_next_q = w_stage_d[DEPTH-2];
    assign w_next_v = w_stage_v[DEPTH-2];
  end

  assign w_diff = w_next_v & (~r_ref_v | (w_next_q != r_ref));

  // Track last valid q and pulse/count when a new valid q differs from it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ref   <= RESET_VAL;
      r_ref_v <= 1'b0;
      r_chg   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_ref_v <= 1'b0;
      r_chg   <= 1'b0;
    end else if (enable) begin
      r_chg <= w_diff;
      if (w_next_v) begin
        r_ref   <= w_next_q;
        r_ref_v <= 1'b1;
      end
      if (w_diff && (r_cnt != CHG_CNT_MAX)) begin
        r_cnt <= r_cnt + CHG_CNT_W'(1);
      end
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign q_changed  = r_chg;
  assign change_cnt = r_cnt;
`else
  assign q_changed  = 1'b0;
  assign change_cnt = '0;
`endif

endmodule : dff_pipe_en
